// File: rtl/aes_sbox_lanes.sv
// Multi-lane sequenced AES S-box engine: a BYTES-wide request is substituted
// LANES bytes per beat (forward or inverse) and returned on a valid/ready channel.
module aes_sbox_lanes #(
  parameter int BYTES   = 16,
  parameter int LANES   = 4,
  parameter int REG_MID = 0
) (
  input  logic               g_clk,
  input  logic               g_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_inv,
  input  logic [8*BYTES-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8*BYTES-1:0] rsp_data,
  output logic               busy
);

  if (LANES < 1 || LANES > BYTES || (BYTES % LANES) != 0) begin : g_bad_cfg
    $error("aes_sbox_lanes: LANES must divide BYTES with 1 <= LANES <= BYTES");
  end

  localparam int BEATS = BYTES / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BP    = 1 << BW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Top layer of the inverse path and output layer of the forward path.
  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Shared middle layer: x^254 = x^-1 in GF(2^8), with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic          inv_q;
  logic [7:0]    buf_q    [BYTES];
  logic [7:0]    buf_d    [BYTES];
  logic [7:0]    view     [BP][LANES];
  logic [7:0]    lane_out [LANES];
  logic [BW-1:0] rd_idx;
  logic [CW-1:0] wb_beat;
  logic          wb_en;
  logic          accept;
  logic          last_beat;

  assign req_ready = (state == S_IDLE) & ~g_rst;
  assign rsp_valid = (state == S_DONE) & ~g_rst;
  assign busy      = ((state == S_RUN) || (state == S_DRAIN)) & ~g_rst;
  assign accept    = req_valid & req_ready;
  assign last_beat = (cnt == CW'(BEATS - 1));

  // With the mid register, the beat written back lags the beat being read by one.
  assign wb_beat = (REG_MID != 0) ? cnt - CW'(1) : cnt;
  assign wb_en   = (REG_MID != 0) ? ((state == S_RUN && cnt != '0) || state == S_DRAIN)
                                  : (state == S_RUN);

  always_comb begin
    rd_idx = '0;
    if (cnt < CW'(BEATS)) rd_idx = cnt[BW-1:0];
  end

  for (genvar b = 0; b < BP; b++) begin : g_view
    for (genvar j = 0; j < LANES; j++) begin : g_col
      if (b < BEATS) begin : g_real
        assign view[b][j] = buf_q[b*LANES + j];
      end else begin : g_pad
        assign view[b][j] = 8'h00;
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] top, mid, z;
    assign top = inv_q ? inv_affine(view[rd_idx][j]) : view[rd_idx][j];
    assign mid = gf_inv(top);
    if (REG_MID != 0) begin : g_mid_reg
      logic [7:0] mid_q;
      // NOTE: pure pipeline data qualified by wb_en, so it carries no reset.
      always_ff @(posedge g_clk) mid_q <= mid;
      assign z = mid_q;
    end else begin : g_mid_comb
      assign z = mid;
    end
    assign lane_out[j] = inv_q ? z : affine(z);
  end

  for (genvar s = 0; s < BYTES; s++) begin : g_slot
    assign buf_d[s] = accept ? req_data[8*s +: 8]
                    : (wb_en && wb_beat == CW'(s / LANES)) ? lane_out[s % LANES]
                    : buf_q[s];
    assign rsp_data[8*s +: 8] = g_rst ? 8'h00 : buf_q[s];
  end

  // NOTE: synchronous reset; all state updates are non-blocking so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      inv_q <= 1'b0;
      buf_q <= '{default: '0};
    end else begin
      buf_q <= buf_d;
      case (state)
        S_IDLE: if (accept) begin
          state <= S_RUN;
          cnt   <= '0;
          inv_q <= req_inv;
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (last_beat) state <= (REG_MID != 0) ? S_DRAIN : S_DONE;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_lanes.sv
// Directed bench for aes_sbox_lanes: four configurations share one stimulus
// stream and are checked against the FIPS-197 S-box table.
module tb_aes_sbox_lanes;

  logic         g_clk = 1'b0;
  logic         g_rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_inv = 1'b0;
  logic         rsp_ready = 1'b1;
  logic [127:0] req_data = '0;

  logic [3:0]   rdy, vld, bsy;
  logic [127:0] q0, q1, q2;
  logic [31:0]  q3;
  logic [127:0] q [4];

  assign q[0] = q0;
  assign q[1] = q1;
  assign q[2] = q2;
  assign q[3] = {96'h0, q3};

  always #5 g_clk = ~g_clk;

  // Configurations: 0=(16,4,0) 1=(16,16,1) 2=(16,4,1) 3=(4,1,0)
  aes_sbox_lanes #(.BYTES(16), .LANES(4), .REG_MID(0)) u_d0 (
    .g_clk(g_clk), .g_rst(g_rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_inv(req_inv), .req_data(req_data), .rsp_valid(vld[0]),
    .rsp_ready(rsp_ready), .rsp_data(q0), .busy(bsy[0]));
  aes_sbox_lanes #(.BYTES(16), .LANES(16), .REG_MID(1)) u_d1 (
    .g_clk(g_clk), .g_rst(g_rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_inv(req_inv), .req_data(req_data), .rsp_valid(vld[1]),
    .rsp_ready(rsp_ready), .rsp_data(q1), .busy(bsy[1]));
  aes_sbox_lanes #(.BYTES(16), .LANES(4), .REG_MID(1)) u_d2 (
    .g_clk(g_clk), .g_rst(g_rst), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_inv(req_inv), .req_data(req_data), .rsp_valid(vld[2]),
    .rsp_ready(rsp_ready), .rsp_data(q2), .busy(bsy[2]));
  aes_sbox_lanes #(.BYTES(4), .LANES(1), .REG_MID(0)) u_d3 (
    .g_clk(g_clk), .g_rst(g_rst), .req_valid(req_valid), .req_ready(rdy[3]),
    .req_inv(req_inv), .req_data(req_data[31:0]), .rsp_valid(vld[3]),
    .rsp_ready(rsp_ready), .rsp_data(q3), .busy(bsy[3]));

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  logic [7:0] inv_sbox [256];

  localparam logic [127:0] INC     = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] FWD_INC = 128'h76ABD7FE2B670130C56F6BF27B777C63;
  localparam logic [127:0] ALL63   = {16{8'h63}};
  localparam logic [127:0] ONE19   = {{15{8'h63}}, 8'hD4};

  int           lat_exp [4] = '{4, 2, 5, 4};
  int           n_vec = 0;
  int           n_err = 0;
  int           t_lat [4];
  logic [127:0] t_got [4];
  int           t_busy;

  function automatic logic [127:0] exp_word(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = d[8*i +: 8];
      r[8*i +: 8] = inv ? inv_sbox[b] : sbox[b];
    end
    return r;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (rdy !== 4'hF && t < 50) begin
      @(negedge g_clk);
      t++;
    end
    n_vec++;
    if (rdy !== 4'hF) begin
      n_err++;
      $display("FAIL wait_idle: req_ready=%b required=1111", rdy);
    end
  endtask

  // One accepted request on every configuration; records latency and result.
  task automatic run_txn(input logic [127:0] d, input logic inv);
    bit all_seen;
    wait_idle();
    req_data  = d;
    req_inv   = inv;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    t_busy = 0;
    for (int k = 0; k < 4; k++) begin
      t_lat[k] = -1;
      t_got[k] = '0;
    end
    for (int c = 0; c < 20; c++) begin
      if (bsy[0]) t_busy++;
      all_seen = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (vld[k] && t_lat[k] < 0) begin
          t_lat[k] = c;
          t_got[k] = q[k];
        end
        if (t_lat[k] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(negedge g_clk);
    end
  endtask

  task automatic test_reset();
    g_rst = 1'b1;
    repeat (3) @(negedge g_clk);
    n_vec++;
    if (rdy !== 4'h0) begin
      n_err++;
      $display("FAIL reset_ready_low: got=%b exp=0000", rdy);
    end
    g_rst = 1'b0;
    #1;
    n_vec += 4;
    if (rdy !== 4'hF) begin n_err++; $display("FAIL reset_ready: got=%b exp=1111", rdy); end
    if (vld !== 4'h0) begin n_err++; $display("FAIL reset_valid: got=%b exp=0000", vld); end
    if (bsy !== 4'h0) begin n_err++; $display("FAIL reset_busy: got=%b exp=0000", bsy); end
    if (q0 !== '0)    begin n_err++; $display("FAIL reset_data: got=%h exp=0", q0); end
  endtask

  task automatic test_basic();
    run_txn('0, 1'b0);
    n_vec += 3;
    if (t_lat[0] !== 4)  begin n_err++; $display("FAIL zero_latency: got=%0d exp=4", t_lat[0]); end
    if (t_got[0] !== ALL63) begin n_err++; $display("FAIL zero_data: got=%h exp=%h", t_got[0], ALL63); end
    if (t_busy !== 4)    begin n_err++; $display("FAIL zero_busy: got=%0d exp=4", t_busy); end
  endtask

  task automatic test_round_trip();
    run_txn(INC, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec += 2;
      if (t_got[k] !== FWD_INC) begin n_err++; $display("FAIL fwd_inc[%0d]: got=%h exp=%h", k, t_got[k], FWD_INC); end
      if (t_lat[k] !== lat_exp[k]) begin n_err++; $display("FAIL fwd_lat[%0d]: got=%0d exp=%0d", k, t_lat[k], lat_exp[k]); end
    end
    n_vec++;
    if (t_got[3][31:0] !== 32'h7B777C63) begin n_err++; $display("FAIL fwd_inc[3]: got=%h exp=7b777c63", t_got[3][31:0]); end
    run_txn(FWD_INC, 1'b1);
    n_vec += 2;
    if (t_got[0] !== INC) begin n_err++; $display("FAIL inv_inc: got=%h exp=%h", t_got[0], INC); end
    if (t_got[3][31:0] !== 32'h03020100) begin n_err++; $display("FAIL inv_inc[3]: got=%h exp=03020100", t_got[3][31:0]); end
    run_txn(128'h19, 1'b0);
    n_vec++;
    if (t_got[0] !== ONE19) begin n_err++; $display("FAIL byte_19: got=%h exp=%h", t_got[0], ONE19); end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, e;
    int t = 0;
    d = 128'h00112233445566778899AABBCCDDEEFF;
    e = exp_word(d, 1'b0);
    wait_idle();
    rsp_ready = 1'b0;
    req_data  = d;
    req_inv   = 1'b0;
    req_valid = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    repeat (3) begin
      req_inv  = ~req_inv;
      req_data = ~req_data ^ {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge g_clk);
    end
    while (!vld[0] && t < 20) begin
      @(negedge g_clk);
      t++;
    end
    n_vec++;
    if (vld[0] !== 1'b1) begin n_err++; $display("FAIL bp_timeout: rsp_valid=%b exp=1", vld[0]); end
    for (int c = 0; c < 10; c++) begin
      n_vec += 3;
      if (vld[0] !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc%0d: got=%b exp=1", c, vld[0]); end
      if (q0 !== e)        begin n_err++; $display("FAIL bp_data cyc%0d: got=%h exp=%h", c, q0, e); end
      if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc%0d: got=%b exp=0", c, rdy[0]); end
      @(negedge g_clk);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    n_vec += 2;
    if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got=%b exp=1", rdy[0]); end
    if (vld[0] !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got=%b exp=0", vld[0]); end
    req_inv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    int seen = 0;
    d = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    wait_idle();
    rsp_ready = 1'b1;
    req_data  = d;
    req_inv   = 1'b0;
    req_valid = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    repeat (2) @(negedge g_clk);
    g_rst = 1'b1;
    @(negedge g_clk);
    g_rst = 1'b0;
    #1;
    n_vec += 4;
    if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got=%b exp=0", bsy[0]); end
    if (vld[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got=%b exp=0", vld[0]); end
    if (q0 !== '0)       begin n_err++; $display("FAIL rst_mid_data: got=%h exp=0", q0); end
    if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got=%b exp=1", rdy[0]); end
    for (int c = 0; c < 10; c++) begin
      @(negedge g_clk);
      if (vld[0]) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_mid_ghost: got=%0d responses exp=0", seen); end
    run_txn(d, 1'b1);
    n_vec += 2;
    if (t_got[0] !== exp_word(d, 1'b1)) begin n_err++; $display("FAIL rst_mid_after: got=%h exp=%h", t_got[0], exp_word(d, 1'b1)); end
    if (t_lat[0] !== 4) begin n_err++; $display("FAIL rst_mid_lat: got=%0d exp=4", t_lat[0]); end
  endtask

  task automatic test_exhaustive();
    logic [127:0] d, e;
    for (int dir = 0; dir < 2; dir++) begin
      for (int k = 0; k < 64; k++) begin
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'((4*k + i) % 256);
        e = exp_word(d, dir[0]);
        run_txn(d, dir[0]);
        for (int m = 0; m < 4; m++) begin
          n_vec += 2;
          if (m < 3 && t_got[m] !== e) begin
            n_err++; $display("FAIL exh[%0d] dir%0d k%0d: got=%h exp=%h", m, dir, k, t_got[m], e);
          end
          if (m == 3 && t_got[3][31:0] !== e[31:0]) begin
            n_err++; $display("FAIL exh[3] dir%0d k%0d: got=%h exp=%h", dir, k, t_got[3][31:0], e[31:0]);
          end
          if (t_lat[m] !== lat_exp[m]) begin
            n_err++; $display("FAIL exh_lat[%0d] dir%0d k%0d: got=%0d exp=%0d", m, dir, k, t_lat[m], lat_exp[m]);
          end
        end
      end
    end
  endtask

  task automatic test_stress();
    logic [127:0] sb [$];
    logic [127:0] e;
    int sent = 0, rcvd = 0, cyc = 0;
    bit fire = 1'b0;
    wait_idle();
    req_valid = 1'b0;
    while (rcvd < 500 && cyc < 20000) begin
      @(negedge g_clk);
      cyc++;
      if (fire) begin
        req_valid = 1'b0;
        fire = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (vld[0] && rsp_ready) begin
        n_vec++;
        rcvd++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stress_spurious: response %0d with empty scoreboard", rcvd);
        end else begin
          e = sb.pop_front();
          if (q0 !== e) begin n_err++; $display("FAIL stress_data #%0d: got=%h exp=%h", rcvd, q0, e); end
        end
      end
      if (!req_valid && sent < 500 && $urandom_range(0, 2) != 0) begin
        req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_inv   = 1'($urandom_range(0, 1));
        req_valid = 1'b1;
      end
      if (req_valid && rdy[0]) begin
        sb.push_back(exp_word(req_data, req_inv));
        sent++;
        fire = 1'b1;
      end
    end
    @(negedge g_clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n_vec++;
    if (rcvd !== 500 || sb.size() !== 0) begin
      n_err++; $display("FAIL stress_count: received=%0d pending=%0d exp=500/0", rcvd, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    test_reset();
    test_basic();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_stress();
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
